// File: rtl/seq_match_ctrl_if.sv
// seq_match_ctrl_if: config, control and serial-stream bundle for seq_match_ctrl
// master (bench/control side) drives cfg_*, start, abort, in_valid, in;
// slave (seq_match_ctrl) drives cfg_ready, detect, busy, done, match_count.
interface seq_match_ctrl_if #(
   parameter int PAT_W = 8,
   parameter int CNT_W = 8,
   parameter int LEN_W = $clog2(PAT_W) + 1
);
   logic             cfg_valid;
   logic             cfg_ready;
   logic [PAT_W-1:0] cfg_pattern;
   logic [LEN_W-1:0] cfg_len;
   logic             cfg_overlap;
   logic [CNT_W-1:0] cfg_target;
   logic             start;
   logic             abort;
   logic             in_valid;
   logic             in;
   logic             detect;
   logic             busy;
   logic             done;
   logic [CNT_W-1:0] match_count;
   modport master (
      output cfg_valid, cfg_pattern, cfg_len, cfg_overlap, cfg_target, start, abort, in_valid, in,
      input  cfg_ready, detect, busy, done, match_count
   );
   modport slave (
      input  cfg_valid, cfg_pattern, cfg_len, cfg_overlap, cfg_target, start, abort, in_valid, in,
      output cfg_ready, detect, busy, done, match_count
   );
endinterface

// File: rtl/seq_match_ctrl.sv
// seq_match_ctrl: programmable serial pattern detector with arm/abort and match target
// Ports: clk, rst (sync, active-low), bus (seq_match_ctrl_if.slave: config write,
// start/abort, qualified serial bit, Mealy detect, busy/done, match_count).
// Macro SEQ_MATCH_OVERLAP_EN: when defined, cfg_overlap is stored and overlapping matches work.
module seq_match_ctrl #(
   parameter int PAT_W = 8,
   parameter int CNT_W = 8,
   parameter int LEN_W = $clog2(PAT_W) + 1
) (
   input logic clk,
   input logic rst,
   seq_match_ctrl_if.slave bus
);
   typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, DONE = 2'd2} state_t;
   state_t           r_state;
   logic [PAT_W-1:0] r_pattern;
   logic [PAT_W-2:0] r_hist;
   logic [LEN_W-1:0] r_len;
   logic [LEN_W-1:0] r_fill;
   logic [CNT_W-1:0] r_target;
   logic [CNT_W-1:0] r_count;
   logic             r_busy;
   logic             r_done;
   logic             r_ready;
   logic [PAT_W-1:0] w_word;
   logic [PAT_W-1:0] w_mask;
   logic [LEN_W:0]   w_fill_inc;
   logic [LEN_W-1:0] w_fill_sat;
   logic [LEN_W-1:0] w_len_in;
   logic [CNT_W-1:0] w_count_inc;
   logic             w_match;
   logic             w_detect;
   logic             w_overlap;
`ifdef SEQ_MATCH_OVERLAP_EN
   logic             r_overlap;
   assign w_overlap = r_overlap;
`else
   assign w_overlap = 1'b0;
`endif
   assign w_word      = {r_hist, bus.in};
   // low r_len bits set; a shift by PAT_W yields all ones
   assign w_mask      = ~({PAT_W{1'b1}} << r_len);
   assign w_fill_inc  = {1'b0, r_fill} + (LEN_W+1)'(1);
   assign w_fill_sat  = (w_fill_inc > (LEN_W+1)'(PAT_W)) ? LEN_W'(PAT_W) : w_fill_inc[LEN_W-1:0];
   assign w_match     = (w_fill_inc >= {1'b0, r_len}) && (((w_word ^ r_pattern) & w_mask) == '0);
   assign w_detect    = (r_state == ARMED) && bus.in_valid && w_match && !bus.abort;
   assign w_len_in    = (bus.cfg_len == '0) ? LEN_W'(1) :
                        (bus.cfg_len > LEN_W'(PAT_W)) ? LEN_W'(PAT_W) : bus.cfg_len;
   assign w_count_inc = (r_count == '1) ? r_count : r_count + CNT_W'(1);
   assign bus.detect      = w_detect;
   assign bus.busy        = r_busy;
   assign bus.done        = r_done;
   assign bus.cfg_ready   = r_ready;
   assign bus.match_count = r_count;
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state   <= IDLE;
         r_pattern <= PAT_W'(10);
         r_len     <= LEN_W'(4);
         r_target  <= '0;
         r_hist    <= '0;
         r_fill    <= '0;
         r_count   <= '0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_ready   <= 1'b1;
`ifdef SEQ_MATCH_OVERLAP_EN
         r_overlap <= 1'b0;
`endif
      end else if (r_state != ARMED) begin
         if (bus.cfg_valid) begin
            r_pattern <= bus.cfg_pattern;
            r_len     <= w_len_in;
            r_target  <= bus.cfg_target;
`ifdef SEQ_MATCH_OVERLAP_EN
            r_overlap <= bus.cfg_overlap;
`endif
         end
         if (bus.start) begin
            r_state <= ARMED;
            r_hist  <= '0;
            r_fill  <= '0;
            r_count <= '0;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
            r_ready <= 1'b0;
         end
      end else if (bus.abort) begin
         r_state <= IDLE;
         r_busy  <= 1'b0;
         r_ready <= 1'b1;
      end else if (bus.in_valid) begin
         r_hist <= w_word[PAT_W-2:0];
         // non-overlap discards the matched bits by restarting the fill
         r_fill <= (w_match && !w_overlap) ? '0 : w_fill_sat;
         if (w_match) begin
            r_count <= w_count_inc;
            if (r_target != '0 && w_count_inc == r_target) begin
               r_state <= DONE;
               r_busy  <= 1'b0;
               r_done  <= 1'b1;
               r_ready <= 1'b1;
            end
         end
      end
   end
endmodule

// File: tb/tb_seq_match_ctrl.sv
// tb_seq_match_ctrl: table-driven, hand-sequence and random checks of seq_match_ctrl against a queue-based model
module tb_seq_match_ctrl;
`ifdef SEQ_MATCH_OVERLAP_EN
   localparam bit OVL = 1'b1;
`else
   localparam bit OVL = 1'b0;
`endif
   typedef struct {
      bit         r;
      bit         cv;
      logic [7:0] pat;
      logic [3:0] len;
      bit         ov;
      logic [7:0] tg;
      bit         st;
      bit         ab;
      bit         iv;
      bit         b;
      bit         xd;
      logic [7:0] xc;
   } vec_t;
   logic clk = 1'b0;
   logic rst;
   int   n_cmp = 0;
   int   n_bad = 0;
   int         m_state;
   logic [7:0] m_pat;
   logic [7:0] m_tgt;
   logic [7:0] m_cnt;
   int         m_len;
   bit         m_ovl;
   bit         m_bits[$];
   vec_t       tbl[$];
   vec_t       seq[$];
   seq_match_ctrl_if bus ();
   seq_match_ctrl dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;
   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
      n_cmp++;
      if (a !== e) begin
         n_bad++;
         $display("FAIL %s at %0t: got %0h want %0h", n, $time, a, e);
      end
   endtask
   function automatic vec_t mk(bit r, bit cv, logic [7:0] pat, logic [3:0] len, bit ov, logic [7:0] tg,
                               bit st, bit ab, bit iv, bit b, bit xd, logic [7:0] xc);
      vec_t v;
      v.r = r; v.cv = cv; v.pat = pat; v.len = len; v.ov = ov; v.tg = tg;
      v.st = st; v.ab = ab; v.iv = iv; v.b = b; v.xd = xd; v.xc = xc;
      return v;
   endfunction
   function automatic vec_t bitv(bit b, bit xd, logic [7:0] xc);
      return mk(1, 0, 0, 0, 0, 0, 0, 0, 1, b, xd, xc);
   endfunction
   function automatic vec_t idlev(logic [7:0] xc);
      return mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, xc);
   endfunction
   function automatic vec_t abortv(logic [7:0] xc);
      return mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, xc);
   endfunction
   function automatic vec_t cfgst(logic [7:0] pat, logic [3:0] len, bit ov, logic [7:0] tg);
      return mk(1, 1, pat, len, ov, tg, 1, 0, 0, 0, 0, 0);
   endfunction
   // last len bits seen since arm (or since the previous non-overlapping match) must spell the pattern
   function automatic bit m_match(bit b);
      bit q[$] = m_bits;
      q.push_back(b);
      if (q.size() < m_len) return 1'b0;
      for (int i = 0; i < m_len; i++)
         if (q[q.size()-1-i] != m_pat[i]) return 1'b0;
      return 1'b1;
   endfunction
   task automatic m_reset();
      m_state = 0; m_pat = 8'h0A; m_len = 4; m_ovl = 1'b0; m_tgt = 0; m_cnt = 0;
      m_bits.delete();
   endtask
   task automatic apply(input vec_t v, input bit use_tbl);
      bit xd;
      @(negedge clk);
      rst = v.r;
      bus.cfg_valid = v.cv; bus.cfg_pattern = v.pat; bus.cfg_len = v.len;
      bus.cfg_overlap = v.ov; bus.cfg_target = v.tg;
      bus.start = v.st; bus.abort = v.ab; bus.in_valid = v.iv; bus.in = v.b;
      #1;
      xd = (m_state == 1) && v.iv && !v.ab && m_match(v.b);
      chk("detect", bus.detect, xd);
      if (use_tbl) chk("detect_vec", bus.detect, v.xd);
      @(posedge clk);
      if (!v.r) m_reset();
      else if (m_state != 1) begin
         if (v.cv) begin
            m_pat = v.pat;
            m_len = (v.len == 0) ? 1 : (v.len > 8) ? 8 : int'(v.len);
            m_ovl = v.ov;
            m_tgt = v.tg;
         end
         if (v.st) begin
            m_state = 1; m_cnt = 0; m_bits.delete();
         end
      end else if (v.ab) m_state = 0;
      else if (v.iv) begin
         m_bits.push_back(v.b);
         if (m_bits.size() > 8) void'(m_bits.pop_front());
         if (xd) begin
            if (m_cnt != 8'hFF) m_cnt++;
            if (!(m_ovl && OVL)) m_bits.delete();
            if (m_tgt != 0 && m_cnt == m_tgt) m_state = 2;
         end
      end
      #1;
      chk("busy", bus.busy, m_state == 1);
      chk("done", bus.done, m_state == 2);
      chk("cfg_ready", bus.cfg_ready, m_state != 1);
      chk("match_count", bus.match_count, m_cnt);
      if (use_tbl) chk("match_count_vec", bus.match_count, v.xc);
   endtask
   initial begin
      rst = 1'b0;
      bus.cfg_valid = 0; bus.cfg_pattern = 0; bus.cfg_len = 0; bus.cfg_overlap = 0;
      bus.cfg_target = 0; bus.start = 0; bus.abort = 0; bus.in_valid = 0; bus.in = 0;
      m_reset();
      repeat (2) @(posedge clk);
      // default non-overlapping 1010
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
      tbl.push_back(bitv(1, 0, 0)); tbl.push_back(bitv(0, 0, 0)); tbl.push_back(bitv(1, 0, 0));
      tbl.push_back(bitv(0, 1, 1)); tbl.push_back(bitv(1, 0, 1)); tbl.push_back(bitv(0, 0, 1));
      // overlap request
      tbl.push_back(abortv(1));
      tbl.push_back(cfgst(8'h0A, 4, 1, 0));
      tbl.push_back(bitv(1, 0, 0)); tbl.push_back(bitv(0, 0, 0)); tbl.push_back(bitv(1, 0, 0));
      tbl.push_back(bitv(0, 1, 1)); tbl.push_back(bitv(1, 0, 1)); tbl.push_back(bitv(0, OVL, 8'(1 + OVL)));
      // target stop at 2 with pattern 101
      tbl.push_back(abortv(8'(1 + OVL)));
      tbl.push_back(cfgst(8'h05, 3, 0, 2));
      tbl.push_back(bitv(1, 0, 0)); tbl.push_back(bitv(0, 0, 0)); tbl.push_back(bitv(1, 1, 1));
      tbl.push_back(bitv(1, 0, 1)); tbl.push_back(bitv(0, 0, 1)); tbl.push_back(bitv(1, 1, 2));
      tbl.push_back(bitv(1, 0, 2)); tbl.push_back(bitv(0, 0, 2)); tbl.push_back(bitv(1, 0, 2));
      for (int i = 0; i < tbl.size(); i++) apply(tbl[i], 1'b1);
      // gapped input then abort on the completing bit
      seq.push_back(cfgst(8'h0A, 4, 0, 0));
      seq.push_back(bitv(1, 0, 0)); seq.push_back(idlev(0)); seq.push_back(bitv(0, 0, 0));
      seq.push_back(idlev(0)); seq.push_back(idlev(0)); seq.push_back(bitv(1, 0, 0));
      seq.push_back(idlev(0));
      seq.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0));
      seq.push_back(idlev(0));
      // config write while armed is refused
      seq.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
      seq.push_back(mk(1, 1, 8'hFF, 1, 1, 1, 0, 0, 0, 0, 0, 0));
      seq.push_back(bitv(1, 0, 0)); seq.push_back(bitv(0, 0, 0)); seq.push_back(bitv(1, 0, 0));
      seq.push_back(bitv(0, 1, 1));
      // length 0 behaves as length 1
      seq.push_back(abortv(1));
      seq.push_back(cfgst(8'h01, 0, 0, 0));
      seq.push_back(bitv(1, 1, 1)); seq.push_back(bitv(0, 0, 1)); seq.push_back(bitv(1, 1, 2));
      // length 12 clamps to 8
      seq.push_back(abortv(2));
      seq.push_back(cfgst(8'hA5, 12, 0, 0));
      seq.push_back(bitv(1, 0, 0)); seq.push_back(bitv(0, 0, 0)); seq.push_back(bitv(1, 0, 0));
      seq.push_back(bitv(0, 0, 0)); seq.push_back(bitv(0, 0, 0)); seq.push_back(bitv(1, 0, 0));
      seq.push_back(bitv(0, 0, 0)); seq.push_back(bitv(1, 1, 1));
      // reset mid-match restores the default 1010 config
      seq.push_back(abortv(1));
      seq.push_back(cfgst(8'h0C, 4, 1, 3));
      seq.push_back(bitv(1, 0, 0)); seq.push_back(bitv(1, 0, 0)); seq.push_back(bitv(0, 0, 0));
      seq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      seq.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
      seq.push_back(bitv(1, 0, 0)); seq.push_back(bitv(0, 0, 0)); seq.push_back(bitv(1, 0, 0));
      seq.push_back(bitv(0, 1, 1));
      for (int i = 0; i < seq.size(); i++) apply(seq[i], 1'b1);
      // randomized traffic against the model
      for (int i = 0; i < 4000; i++) begin
         vec_t v;
         v = mk($urandom_range(0, 99) != 0, $urandom_range(0, 3) == 0, 8'($urandom),
                4'($urandom_range(0, 12)), 1'($urandom), 8'($urandom_range(0, 3)),
                $urandom_range(0, 7) == 0, $urandom_range(0, 31) == 0,
                $urandom_range(0, 3) != 0, 1'($urandom), 0, 0);
         if ($urandom_range(0, 1) == 1) v.len = 4'($urandom_range(0, 3));
         apply(v, 1'b0);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/seq_match_ctrl.md
# seq_match_ctrl

- Programmable controller for the serial sequence-detection datapath.
- Holds the pattern configuration and arms/disarms matching on a qualified serial bit stream.
- Emits a Mealy detect pulse per match, counts matches, and stops at a programmed target count.
- Sits between the control/config side and the serial input. It replaces fixed-pattern detectors: reset defaults make it behave as a non-overlapping 1010 detector.

## Interface
- PAT_W, 8: maximum pattern length in bits.
- CNT_W, 8: match counter and target width.
- LEN_W, $clog2(PAT_W)+1: width of cfg_len.

- clk  in  1  rising-edge clock; only clock.
- rst  in  1  synchronous, active-low reset; sampled on rising clk.
- cfg_valid  in  1  config write request.
- cfg_ready  out  1  high when state != ARMED; write accepted on cfg_valid && cfg_ready.
- cfg_pattern  in  PAT_W  pattern; bit [len-1] is the first bit expected on the line.
- cfg_len  in  LEN_W  pattern length; 0 is stored as 1; values >PAT_W are stored as PAT_W.
- cfg_overlap  in  1  1 = overlapping matches allowed.
- cfg_target  in  CNT_W  matches before done; 0 = unlimited.
- start  in  1  arm request; honoured in IDLE or DONE.
- abort  in  1  disarm request; honoured in ARMED.
- in_valid  in  1  qualifies `in` this cycle.
- in  in  1  serial data bit.
- detect  out  1  combinational Mealy match pulse.
- busy  out  1  state == ARMED.
- done  out  1  state == DONE.
- match_count  out  CNT_W  matches since last arm.

## Operation
- **States:**
  - IDLE: reset state; cfg accepted.
  - ARMED: matching.
  - DONE: target reached; cfg accepted.
- **Transitions:**
  - IDLE --start--> ARMED.
  - ARMED --abort--> IDLE.
  - ARMED --final target match--> DONE.
  - DONE --start--> ARMED.
  - start in ARMED is ignored. abort outside ARMED is ignored.
- **Arming:** entering ARMED clears history, fill count and match_count.
- **Matching:** in ARMED, each in_valid cycle does three things:
  - shifts `in` into the history register (LSB = newest);
  - increments fill, saturating at PAT_W;
  - computes match = (fill+1 >= len) && (history[len-2:0],in) == pattern[len-1:0].
- **detect:** = ARMED && in_valid && match && !abort. It is never asserted outside ARMED.
- **Non-overlap:** on a match, fill clears to 0, so the bits of a match are not reused.
- **Overlap:** on a match, fill is kept.
- **Counting:** match_count increments on each detect.
  - When target != 0 and the incremented value equals the target, the next state is DONE.
  - When target = 0, the counter saturates at all-ones and the block stays ARMED.
- **Cycles with in_valid=0:** no shift, no fill change, no detect.
- **Simultaneous events:**
  - abort with a completing bit: abort wins, the bit is dropped, no detect, no count.
  - cfg write with start in IDLE/DONE: the config is written and start is honoured. The new config applies from the first armed cycle.
- **Config registers:** keep their value through ARMED. A change takes effect only via IDLE/DONE writes.

## Timing
- **Reset values:**
  - state IDLE; cfg_ready=1; busy=0; done=0; detect=0; match_count=0.
  - pattern=8'b0000_1010; len=4; overlap=0; target=0.
- **Latency:**
  - detect is asserted in the same cycle as the bit that completes the pattern (zero latency).
  - match_count updates at the following edge.
  - done/busy change at that same edge.
- **Start:** start at edge N gives busy=1 from N. The first bit evaluated is the in_valid bit in the cycle after that edge.
- **Reset mid-operation:** rst=0 on any edge restores all reset values, including config, regardless of state or inputs.
- **Throughput:** one bit per cycle; in_valid may be deasserted arbitrarily.

## Configuration
- **SEQ_MATCH_OVERLAP_EN defined:** cfg_overlap is stored and overlapping mode works as described.
- **SEQ_MATCH_OVERLAP_EN undefined:**
  - the overlap register is not implemented and cfg_overlap is ignored;
  - matching is always non-overlapping;
  - all other behaviour is identical.

## Test plan
- **Default non-overlap:** reset, start, bits 1,0,1,0,1,0 at in_valid=1 → detect only on the 4th bit; match_count=1; busy stays 1.
- **Overlap mode (macro defined):** cfg pattern 1010, len 4, overlap 1, target 0; bits 1,0,1,0,1,0 → detect on the 4th and 6th bits; match_count=2. With the macro undefined → detect only on the 4th bit.
- **Target stop:** cfg pattern 101, len 3, target 2, non-overlap; bits 1,0,1,1,0,1,1,0,1 → detect on bits 3 and 6. done=1 from the edge after bit 6, busy=0. Bit 9 gives no detect; match_count holds 2.
- **Gapped input and abort:** default cfg; bits 1,0,1 with in_valid low cycles between them, then abort in the same cycle as final bit 0 → no detect; state IDLE next edge; match_count=0.
- **Config gating:** cfg_valid while ARMED → cfg_ready=0 and registers unchanged. cfg_len=0 → behaves as len 1 (every bit equal to pattern[0] detects). cfg_len=12 → stored as 8.
- **Reset mid-match:** custom cfg, armed, 3 of 4 bits received; rst=0 one cycle → IDLE, match_count=0, default 1010 config. Start, bits 1,0,1,0 → detect on the 4th bit.
